// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its RAM.
package dmem_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmemState_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, write-enable plus read-enable.
// Latency: read data registered on the enabled edge; store committed on the same edge.
// Backpressure: none; the owner only enables it once per access. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store front end over a DEPTH x 64 RAM (optional DMEM_MISALIGN_CHECK_EN).
// Latency: rsp_valid 1+WAIT_CYCLES cycles after accept; one access per 2+WAIT_CYCLES cycles.
// Backpressure: response held stable until rsp_ready; req_ready is low outside IDLE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    dmemState_e        stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic              writeQ, errQ;
    logic [AW-1:0]     addrQ;
    logic [DATA_W-1:0] wdataQ;

    logic              accept, enterResp, misalign, reqErr;
    logic              curWrite, curErr;
    logic [AW-1:0]     curAddr;
    logic [DATA_W-1:0] curWdata;
    logic              arrEn, arrWe;
    logic [DATA_W-1:0] arrRdata;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = |req_addr[2:0];
`else
    logic unusedAlign;
    assign misalign    = 1'b0;
    assign unusedAlign = ^req_addr[2:0];
`endif

    assign req_ready = (stateQ == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign reqErr    = (req_addr[ADDR_W-1:3] >= (ADDR_W-3)'(DEPTH)) || misalign;

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        enterResp = 1'b0;
        case (stateQ)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        stateD    = RESP;
                        enterResp = 1'b1;
                    end else begin
                        stateD = WAIT;
                        cntD   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cntQ == '0) begin
                    stateD    = RESP;
                    enterResp = 1'b1;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // With zero wait the RAM is touched on the accept edge, before anything is latched.
    assign curWrite = (stateQ == IDLE) ? req_write : writeQ;
    assign curErr   = (stateQ == IDLE) ? reqErr    : errQ;
    assign curAddr  = (stateQ == IDLE) ? req_addr[AW+2:3] : addrQ;
    assign curWdata = (stateQ == IDLE) ? req_wdata : wdataQ;

    // Gating with rst drops a store whose RESP entry coincides with reset.
    assign arrEn = enterResp && !curErr && !rst;
    assign arrWe = arrEn && curWrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            writeQ <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                writeQ <= req_write;
                errQ   <= reqErr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addrQ  <= req_addr[AW+2:3];
            wdataQ <= req_wdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (arrEn),
        .we    (arrWe),
        .addr  (curAddr),
        .wdata (curWdata),
        .rdata (arrRdata)
    );

    assign rsp_valid = (stateQ == RESP) && !rst;
    assign rsp_err   = rsp_valid && errQ;
    assign rsp_rdata = (rsp_valid && !errQ && !writeQ) ? arrRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven through a response scoreboard,
// plus a WAIT_CYCLES=0 instance for streaming throughput.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int WAITS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        reqValid = 1'b0, reqWrite = 1'b0, rspReady = 1'b0;
    logic [63:0] reqAddr = '0, reqWdata = '0;
    logic        reqReady, rspValid, rspErr;
    logic [63:0] rspRdata;

    logic        zReqValid = 1'b0, zReqWrite = 1'b0, zRspReady = 1'b0;
    logic [63:0] zReqAddr = '0, zReqWdata = '0;
    logic        zReqReady, zRspValid, zRspErr;
    logic [63:0] zRspRdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_rdata(rspRdata), .rsp_err(rspErr)
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(zReqValid), .req_ready(zReqReady), .req_write(zReqWrite),
        .req_addr(zReqAddr), .req_wdata(zReqWdata),
        .rsp_valid(zRspValid), .rsp_ready(zRspReady),
        .rsp_rdata(zRspRdata), .rsp_err(zRspErr)
    );

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } rsp_t;

    rsp_t        expQ[$];
    logic [63:0] model [8];
    int          errors = 0;
    int          checks = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on the WAIT_CYCLES=2 instance; hold>0 withholds rsp_ready and
    // tries to sneak in a store to 0x10 while the response is pending.
    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] expData, input logic expErr, input int hold,
                         input string tag);
        int   n;
        rsp_t exp;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wd;
        n = 0;
        while (!reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, "_acc"}, 64'(reqReady), 64'd1);
        if (!reqReady) begin
            reqValid = 1'b0;
            return;
        end
        expQ.push_back(rsp_t'{err: expErr, rdata: expData});
        @(posedge clk);
        #1;
        reqValid = 1'b0; reqWrite = 1'($urandom); reqAddr = {$urandom, $urandom};
        reqWdata = {$urandom, $urandom};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rspValid && n < 20);
        checkVal({tag, "_lat"}, 64'(n), 64'(WAITS + 1));
        if (!rspValid) begin
            exp = expQ.pop_front();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            checkVal({tag, "_hold_v"}, 64'(rspValid), 64'd1);
            checkVal({tag, "_hold_d"}, rspRdata, expQ[0].rdata);
            checkVal({tag, "_hold_rdy"}, 64'(reqReady), 64'd0);
            reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h10;
            reqWdata = 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clk);
        end
        reqValid = 1'b0;
        exp = expQ.pop_front();
        checkVal({tag, "_data"}, rspRdata, exp.rdata);
        checkVal({tag, "_err"}, 64'(rspErr), 64'(exp.err));
        rspReady = 1'b1;
        @(posedge clk);
        #1 rspReady = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r, idx;
        logic        wr;
        logic [63:0] d, expD;
        logic        expE;

        repeat (3) @(negedge clk);
        checkVal("rst_req_ready", 64'(reqReady), 64'd0);
        checkVal("rst_rsp_valid", 64'(rspValid), 64'd0);
        checkVal("rst_rsp_err", 64'(rspErr), 64'd0);
        checkVal("rst_rsp_rdata", rspRdata, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkVal("rst_release_ready", 64'(reqReady), 64'd1);

        issue(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, 0, "st10");
        issue(1'b0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, "ld10");
        issue(1'b0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 5, "bp10");
        issue(1'b0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, "ld10_after_bp");

        issue(1'b1, 64'h0, 64'hA5A5_0000_5A5A_1111, 64'd0, 1'b0, 0, "st0");
        issue(1'b0, 64'h800, 64'd0, 64'd0, 1'b1, 0, "ld_oor");
        issue(1'b1, 64'h800, 64'hFFFF_EEEE_DDDD_CCCC, 64'd0, 1'b1, 0, "st_oor");
        issue(1'b0, 64'h0, 64'd0, 64'hA5A5_0000_5A5A_1111, 1'b0, 0, "ld0");
        issue(1'b1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 0, "st_top");
        issue(1'b0, 64'h7F8, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, "ld_top");

`ifdef DMEM_MISALIGN_CHECK_EN
        issue(1'b0, 64'h13, 64'd0, 64'd0, 1'b1, 0, "misalign");
`else
        issue(1'b0, 64'h13, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, "misalign");
`endif

        issue(1'b1, 64'h20, 64'h1111, 64'd0, 1'b0, 0, "st20_prior");
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h20; reqWdata = 64'h1234;
        checkVal("rstwait_acc", 64'(reqReady), 64'd1);
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkVal("rstwait_req_ready", 64'(reqReady), 64'd0);
        checkVal("rstwait_rsp_valid", 64'(rspValid), 64'd0);
        checkVal("rstwait_rsp_rdata", rspRdata, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkVal("rstwait_release_ready", 64'(reqReady), 64'd1);
        issue(1'b0, 64'h20, 64'd0, 64'h1111, 1'b0, 0, "ld20_after_rst");

        for (int i = 0; i < 8; i++) begin
            model[i] = {$urandom, $urandom};
            issue(1'b1, 64'(i) << 3, model[i], 64'd0, 1'b0, 0, "rnd_init");
        end
        for (int k = 0; k < 24; k++) begin
            r  = $urandom_range(0, 11);
            idx = (r < 8) ? r : 256 + (r - 8);
            wr = 1'($urandom);
            d  = {$urandom, $urandom};
            expD = 64'd0;
            expE = 1'b0;
            if (r >= 8) begin
                expE = 1'b1;
            end else if (wr) begin
                model[r] = d;
            end else begin
                expD = model[r];
            end
            issue(wr, 64'(idx) << 3, d, expD, expE, 0, "rnd");
        end

        @(negedge clk);
        zReqValid = 1'b1; zReqWrite = 1'b1; zReqAddr = 64'h8; zReqWdata = 64'h55AA; zRspReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checkVal("z_req_ready", 64'(zReqReady), 64'(i % 2 == 0));
            checkVal("z_rsp_valid", 64'(zRspValid), 64'(i % 2 == 1));
            @(negedge clk);
        end
        zReqWrite = 1'b0;
        @(posedge clk);
        #1 zReqValid = 1'b0;
        @(negedge clk);
        checkVal("z_ld_valid", 64'(zRspValid), 64'd1);
        checkVal("z_ld_data", zRspRdata, 64'h55AA);
        checkVal("z_ld_err", 64'(zRspErr), 64'd0);
        checkVal("scoreboard_empty", 64'(expQ.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
